regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (RegWre/WriteReg/WriteData) among NREQ write-back producers, e.g. ALU, load unit and multi-cycle unit.
- Each producer has a one-entry holding buffer and a valid/ready handshake; a round-robin arbiter grants one buffered write per cycle.
- A sweep sequencer can clear r1..r31 to zero without asserting the register file's reset.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wb_arbiter.sv | 176 +++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter with a zeroing sweep.
// NREQ producers each get a one-entry holding buffer and a valid/ready handshake.
// Each cycle one buffered write is granted onto the registered write port.
// A sweep sequencer writes zero to r1..r(2^AW-1) without resetting the register file.
// Optional macro WB_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_reg,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               clr_start,
    output logic               RegWre,
    output logic [AW-1:0]      WriteReg,
    output logic [DW-1:0]      WriteData,
    output logic               busy,
    output logic               clr_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW-1:0] LastReg = '1;

    typedef enum logic {StArb, StSweep} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [NREQ-1:0] pend_q;
    logic [AW-1:0]   preg_q  [NREQ];
    logic [DW-1:0]   pdata_q [NREQ];
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] accept;
    logic            any_grant;
    logic [PW-1:0]   gidx;
    logic            wre_d, done_d;
    logic [AW-1:0]   wreg_d;
    logic [DW-1:0]   wdata_d;

`ifdef WB_ARB_FIXED_PRIO_EN
    // Fixed priority: lowest pending index wins; nothing granted during a sweep.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        gidx      = '0;
        if (state_q == StArb) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!any_grant && pend_q[i]) begin
                    grant[i]  = 1'b1;
                    any_grant = 1'b1;
                    gidx      = PW'(i);
                end
            end
        end
    end
`else
    logic [PW-1:0] ptr_q;

    // Round-robin: first pending index at or after the pointer, searching cyclically.
    always_comb begin
        int            idx_w;
        logic [PW-1:0] cand;
        grant     = '0;
        any_grant = 1'b0;
        gidx      = '0;
        idx_w     = 0;
        cand      = '0;
        if (state_q == StArb) begin
            for (int j = 0; j < NREQ; j++) begin
                idx_w = int'(ptr_q) + j;
                if (idx_w >= NREQ) idx_w = idx_w - NREQ;
                cand = PW'(idx_w);
                if (!any_grant && pend_q[cand]) begin
                    grant[cand] = 1'b1;
                    any_grant   = 1'b1;
                    gidx        = cand;
                end
            end
        end
    end

    // Pointer moves past the winner; it only moves on a grant, so it freezes in a sweep.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ptr_q <= '0;
        end else if (any_grant) begin
            ptr_q <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end
    end
`endif

    // A buffer that is being drained this cycle can take a new entry at the same time.
    assign req_ready = (state_q == StArb) ? (~pend_q | grant) : '0;
    assign accept    = req_valid & req_ready;
    assign busy      = (state_q == StSweep);

    // Holding buffers: fill on accept (r0 writes are dropped), clear on grant.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                preg_q[i]  <= '0;
                pdata_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (accept[i] && (req_reg[i*AW +: AW] != '0)) begin
                    pend_q[i]  <= 1'b1;
                    preg_q[i]  <= req_reg[i*AW +: AW];
                    pdata_q[i] <= req_data[i*DW +: DW];
                end else if (grant[i]) begin
                    pend_q[i] <= 1'b0;
                end
            end
        end
    end

    // Next state, sweep counter and next write-port values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wre_d   = 1'b0;
        wreg_d  = WriteReg;
        wdata_d = WriteData;
        done_d  = 1'b0;
        case (state_q)
            StArb: begin
                if (clr_start) begin
                    state_d = StSweep;
                    cnt_d   = AW'(1);
                end
                // A grant in the clr_start cycle still issues ahead of the sweep.
                if (any_grant) begin
                    wre_d   = 1'b1;
                    wreg_d  = preg_q[gidx];
                    wdata_d = pdata_q[gidx];
                end
            end
            StSweep: begin
                wre_d   = 1'b1;
                wreg_d  = cnt_q;
                wdata_d = '0;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LastReg) begin
                    done_d  = 1'b1;
                    state_d = StArb;
                end
            end
            default: state_d = StArb;
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= StArb;
            cnt_q     <= '0;
            RegWre    <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            clr_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            RegWre    <= wre_d;
            WriteReg  <= wreg_d;
            WriteData <= wdata_d;
            clr_done  <= done_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: expected writes are queued as stimulus is
// issued; a negedge monitor pops and compares every cycle RegWre is high.
module tb_regfile_wb_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic               CLK = 1'b0;
    logic               RST = 1'b0;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*AW-1:0] req_reg = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ready;
    logic               clr_start = 1'b0;
    logic               RegWre;
    logic [AW-1:0]      WriteReg;
    logic [DW-1:0]      WriteData;
    logic               busy;
    logic               clr_done;

    int n_vec = 0;
    int n_err = 0;
    logic [AW+DW-1:0] exp_q[$];

    regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_valid (req_valid),
        .req_reg   (req_reg),
        .req_data  (req_data),
        .req_ready (req_ready),
        .clr_start (clr_start),
        .RegWre    (RegWre),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .busy      (busy),
        .clr_done  (clr_done)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
        req_valid[i]           = 1'b1;
        req_reg[i*AW +: AW]    = r;
        req_data[i*DW +: DW]   = d;
    endtask

    task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
        exp_q.push_back({r, d});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
    endtask

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge CLK) begin
        if (RegWre === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wb_unexpected: got r%0d=%h, required no write", WriteReg, WriteData);
            end else begin
                chk("wb_write", 64'({WriteReg, WriteData}), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        #2 RST = 1'b1;
        @(negedge CLK);
        chk("rst_regwre", 64'(RegWre), 64'd0);
        chk("rst_wreg", 64'(WriteReg), 64'd0);
        chk("rst_wdata", 64'(WriteData), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(clr_done), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'b111);
        tick();
        RST = 1'b0;
        tick();

        // Single write, latency 2 edges, one cycle wide
        set_req(0, 5'd5, 32'hDEADBEEF);
        push(5'd5, 32'hDEADBEEF);
        @(negedge CLK);
        chk("single_ready0", 64'(req_ready[0]), 64'd1);
        tick();
        req_valid = '0;
        @(negedge CLK);
        chk("single_lat_t1", 64'(RegWre), 64'd0);
        tick();
        @(negedge CLK);
        chk("single_lat_t2", 64'(RegWre), 64'd1);
        tick();
        @(negedge CLK);
        chk("single_one_cycle", 64'(RegWre), 64'd0);
        idle(2);

        // Contention, pointer at 0: r1, r2, r3
        pulse_reset();
        set_req(0, 5'd1, 32'hA);
        set_req(1, 5'd2, 32'hB);
        set_req(2, 5'd3, 32'hC);
        push(5'd1, 32'hA);
        push(5'd2, 32'hB);
        push(5'd3, 32'hC);
        @(negedge CLK);
        chk("cont_ready", 64'(req_ready), 64'b111);
        tick();
        req_valid = '0;
        idle(5);
        // Move the pointer to 1 with a lone requester-0 write
        set_req(0, 5'd4, 32'h44);
        push(5'd4, 32'h44);
        tick();
        req_valid = '0;
        idle(4);
        // Second round
        set_req(0, 5'd1, 32'h1A);
        set_req(1, 5'd2, 32'h1B);
        set_req(2, 5'd3, 32'h1C);
`ifdef WB_ARB_FIXED_PRIO_EN
        push(5'd1, 32'h1A);
        push(5'd2, 32'h1B);
        push(5'd3, 32'h1C);
`else
        push(5'd2, 32'h1B);
        push(5'd3, 32'h1C);
        push(5'd1, 32'h1A);
`endif
        @(negedge CLK);
        chk("cont2_ready", 64'(req_ready), 64'b111);
        tick();
        req_valid = '0;
        idle(5);

        // Streaming on requester 1: data 1..4 on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            set_req(1, 5'd9, DW'(i + 1));
            push(5'd9, DW'(i + 1));
            @(negedge CLK);
            chk("stream_ready1", 64'(req_ready[1]), 64'd1);
            if (i >= 2) chk("stream_wre", 64'(RegWre), 64'd1);
            tick();
        end
        req_valid = '0;
        @(negedge CLK);
        chk("stream_wre_t4", 64'(RegWre), 64'd1);
        tick();
        @(negedge CLK);
        chk("stream_wre_t5", 64'(RegWre), 64'd1);
        tick();
        @(negedge CLK);
        chk("stream_wre_t6", 64'(RegWre), 64'd0);
        idle(2);

        // Write to r0 is accepted and discarded
        set_req(2, 5'd0, 32'h55);
        @(negedge CLK);
        chk("zero_ready2", 64'(req_ready[2]), 64'd1);
        tick();
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("zero_no_write", 64'(RegWre), 64'd0);
            tick();
        end

        // Sweep with a requester-0 write to r7 offered mid-sweep
        clr_start = 1'b1;
        for (int r = 1; r < 32; r++) push(AW'(r), 32'd0);
        push(5'd7, 32'h77);
        tick();
        clr_start = 1'b0;
        for (int c = 1; c <= 32; c++) begin
            if (c == 5) set_req(0, 5'd7, 32'h77);
            @(negedge CLK);
            chk("sweep_busy", 64'(busy), 64'(c <= 31));
            chk("sweep_done", 64'(clr_done), 64'(c == 32));
            chk("sweep_wre", 64'(RegWre), 64'(c >= 2));
            if (c >= 5) chk("sweep_ready0", 64'(req_ready[0]), 64'(c == 32));
            tick();
        end
        req_valid = '0;
        idle(4);
        chk("sweep_drained", 64'(exp_q.size()), 64'd0);

        // Reset mid-sweep at step 10
        clr_start = 1'b1;
        for (int r = 1; r < 10; r++) push(AW'(r), 32'd0);
        tick();
        clr_start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CLK);
            if (c < 10) tick();
        end
        #1 RST = 1'b1;
        #1;
        chk("midrst_wre", 64'(RegWre), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(clr_done), 64'd0);
        tick();
        RST = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            if (k % 10 == 0) chk("post_rst_busy", 64'(busy), 64'd0);
            tick();
        end
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
